load_store_unit: RTL and testbench

Initiator side of the CPU's synchronous single-port memory. It accepts one load or store request at a time from the core over a valid/ready handshake. It drives the memory's `addr` / `write_enable` / `data_in` port and waits out the fixed read latency. It returns the load data, or a store completion, on a valid/ready response channel.

---
 rtl/lsu_pkg.sv | 14 +
 rtl/load_store_unit_if.sv | 36 +++
 rtl/load_store_unit.sv | 95 +++++++++
 tb/tb_load_store_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and width defaults for the load/store unit.
package lsu_pkg;

  localparam int unsigned LSU_ADDR_W = 12;
  localparam int unsigned LSU_DATA_W = 12;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_WRITE,
    LSU_READ,
    LSU_RESP
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response channels plus the single-port memory port of the load/store unit.
interface load_store_unit_if
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = LSU_ADDR_W,
  parameter int unsigned DATA_W = LSU_DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_write_enable;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  // The master side is everything around the LSU: the core and the memory.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_data_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_write_enable, mem_data_in
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_data_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_write_enable, mem_data_in
  );

endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for a synchronous single-port memory.
// Define LSU_BOUNDS_CHECK_EN to flag addresses >= MEM_SIZE with rsp_err instead of accessing.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W       = LSU_ADDR_W,
  parameter int unsigned DATA_W       = LSU_DATA_W,
  parameter int unsigned MEM_SIZE     = 4096,
  parameter int unsigned READ_LATENCY = 1
) (
  input logic             clk,
  input logic             rst_n,
  load_store_unit_if.slave bus
);

  localparam int unsigned CntW = $clog2(READ_LATENCY + 1);

  lsu_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic            in_range;

`ifdef LSU_BOUNDS_CHECK_EN
  assign in_range = 32'(bus.req_addr) < MEM_SIZE;
`else
  logic unused_mem_size;
  assign unused_mem_size = ^MEM_SIZE;
  assign in_range        = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q              <= LSU_IDLE;
      cnt_q                <= '0;
      bus.req_ready        <= 1'b0;
      bus.rsp_valid        <= 1'b0;
      bus.rsp_err          <= 1'b0;
      bus.rsp_rdata        <= '0;
      bus.mem_addr         <= '0;
      bus.mem_write_enable <= 1'b0;
      bus.mem_data_in      <= '0;
    end else begin
      unique case (state_q)
        LSU_IDLE: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            if (!in_range) begin
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= '0;
              state_q       <= LSU_RESP;
            end else begin
              bus.rsp_err  <= 1'b0;
              bus.mem_addr <= bus.req_addr;
              if (bus.req_we) begin
                bus.mem_data_in      <= bus.req_wdata;
                bus.mem_write_enable <= 1'b1;
                state_q              <= LSU_WRITE;
              end else begin
                cnt_q   <= CntW'(READ_LATENCY);
                state_q <= LSU_READ;
              end
            end
          end
        end
        LSU_WRITE: begin
          bus.mem_write_enable <= 1'b0;
          bus.rsp_rdata        <= '0;
          bus.rsp_err          <= 1'b0;
          state_q              <= LSU_RESP;
        end
        LSU_READ: begin
          // Counter hits zero exactly when the memory has had READ_LATENCY edges since sampling.
          if (cnt_q == '0) begin
            bus.rsp_rdata <= bus.mem_data_out;
            state_q       <= LSU_RESP;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        LSU_RESP: begin
          // First RESP edge only raises valid; the handshake is taken from the next edge on.
          if (!bus.rsp_valid) begin
            bus.rsp_valid <= 1'b1;
          end else if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state_q       <= LSU_IDLE;
          end
        end
        default: state_q <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised bench for load_store_unit: two DUTs (latency 1 and 3) against a behavioural model.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int unsigned MemSize1 = 1337;
  localparam int unsigned Lat3     = 3;
`ifdef LSU_BOUNDS_CHECK_EN
  localparam bit BoundsEn = 1'b1;
`else
  localparam bit BoundsEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;
  logic        req_valid, req_we, rsp_ready;
  logic [11:0] req_addr, req_wdata;
  logic        mem_clear;

  load_store_unit_if #(.ADDR_W(12), .DATA_W(12)) bus1 ();
  load_store_unit_if #(.ADDR_W(12), .DATA_W(12)) bus3 ();

  load_store_unit #(
    .ADDR_W(12), .DATA_W(12), .MEM_SIZE(MemSize1), .READ_LATENCY(1)
  ) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  load_store_unit #(
    .ADDR_W(12), .DATA_W(12), .MEM_SIZE(4096), .READ_LATENCY(Lat3)
  ) u_dut3 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus3)
  );

  assign bus1.req_valid = req_valid & ~sel;
  assign bus3.req_valid = req_valid & sel;
  assign bus1.rsp_ready = rsp_ready & ~sel;
  assign bus3.rsp_ready = rsp_ready & sel;
  assign bus1.req_we    = req_we;
  assign bus3.req_we    = req_we;
  assign bus1.req_addr  = req_addr;
  assign bus3.req_addr  = req_addr;
  assign bus1.req_wdata = req_wdata;
  assign bus3.req_wdata = req_wdata;

  logic        o_req_ready, o_rsp_valid, o_rsp_err, o_mem_we;
  logic [11:0] o_rsp_rdata, o_mem_addr, o_mem_din;
  assign o_req_ready = sel ? bus3.req_ready        : bus1.req_ready;
  assign o_rsp_valid = sel ? bus3.rsp_valid        : bus1.rsp_valid;
  assign o_rsp_err   = sel ? bus3.rsp_err          : bus1.rsp_err;
  assign o_rsp_rdata = sel ? bus3.rsp_rdata        : bus1.rsp_rdata;
  assign o_mem_we    = sel ? bus3.mem_write_enable : bus1.mem_write_enable;
  assign o_mem_addr  = sel ? bus3.mem_addr         : bus1.mem_addr;
  assign o_mem_din   = sel ? bus3.mem_data_in      : bus1.mem_data_in;

  // Memory stubs: synchronous single-port RAMs with 1 and 3 edges of read latency.
  logic [11:0] mem1 [4096];
  logic [11:0] mem3 [4096];
  logic [11:0] pipe3 [3];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 4096; i++) mem1[i] <= '0;
    end else if (bus1.mem_write_enable) begin
      mem1[bus1.mem_addr] <= bus1.mem_data_in;
    end
    bus1.mem_data_out <= mem1[bus1.mem_addr];
  end

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 4096; i++) mem3[i] <= '0;
    end else if (bus3.mem_write_enable) begin
      mem3[bus3.mem_addr] <= bus3.mem_data_in;
    end
    pipe3[0] <= mem3[bus3.mem_addr];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign bus3.mem_data_out = pipe3[2];

  // Reference contents of each DUT's memory as seen through completed stores.
  logic [11:0] ref_mem [2][4096];
  int n_vectors     = 0;
  int n_miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic run_txn(input bit s, input bit we, input logic [11:0] addr,
                         input logic [11:0] wdata, input int unsigned hold);
    bit          exp_err;
    int          exp_lat;
    logic [11:0] exp_rdata;
    int          n;
    int          we_cycles;
    exp_err   = !s && BoundsEn && (32'(addr) >= MemSize1);
    exp_lat   = exp_err ? 1 : (we ? 2 : (s ? Lat3 : 1) + 2);
    exp_rdata = (exp_err || we) ? 12'h000 : ref_mem[s][addr];

    @(negedge clk);
    sel = s;
    n   = 0;
    while (!o_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_ready_idle", o_req_ready, 1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    rsp_ready = (hold == 0);

    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = 12'($urandom);
    req_wdata = 12'($urandom);
    check_eq("req_ready_busy", o_req_ready, 0);

    we_cycles = 0;
    n         = 0;
    while (!o_rsp_valid && n < 20) begin
      if (!exp_err) check_eq("mem_addr", o_mem_addr, addr);
      if (o_mem_we) begin
        we_cycles++;
        check_eq("mem_data_in", o_mem_din, wdata);
      end
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("rsp_latency", n, exp_lat);
    check_eq("we_cycles", we_cycles, (we && !exp_err) ? 1 : 0);
    check_eq("rsp_rdata", o_rsp_rdata, exp_rdata);
    check_eq("rsp_err", o_rsp_err, exp_err);

    for (int i = 0; i < int'(hold); i++) begin
      req_valid = 1'($urandom);
      @(posedge clk);
      #1;
      check_eq("hold_valid", o_rsp_valid, 1);
      check_eq("hold_rdata", o_rsp_rdata, exp_rdata);
      check_eq("hold_err", o_rsp_err, exp_err);
      check_eq("hold_req_ready", o_req_ready, 0);
      check_eq("hold_mem_we", o_mem_we, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rsp_done", o_rsp_valid, 0);
    check_eq("ready_again", o_req_ready, 1);
    rsp_ready = 1'b0;

    if (we && !exp_err) ref_mem[s][addr] = wdata;
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_clear = 1'b1;
    sel       = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      ref_mem[0][i] = '0;
      ref_mem[1][i] = '0;
    end

    #1;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      check_eq("rst_req_ready", o_req_ready, 0);
      check_eq("rst_rsp_valid", o_rsp_valid, 0);
      check_eq("rst_rsp_err", o_rsp_err, 0);
      check_eq("rst_rsp_rdata", o_rsp_rdata, 0);
      check_eq("rst_mem_addr", o_mem_addr, 0);
      check_eq("rst_mem_we", o_mem_we, 0);
      check_eq("rst_mem_din", o_mem_din, 0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_clear = 1'b0;
    rst_n     = 1'b1;
    sel       = 1'b0;

    run_txn(1'b0, 1'b1, 12'h005, 12'hABC, 0);
    run_txn(1'b0, 1'b0, 12'h005, 12'h000, 0);
    run_txn(1'b1, 1'b1, 12'h005, 12'hABC, 0);
    run_txn(1'b1, 1'b0, 12'h005, 12'h000, 0);
    run_txn(1'b0, 1'b1, 12'h123, 12'h456, 0);
    run_txn(1'b0, 1'b0, 12'h123, 12'h000, 4);
    run_txn(1'b0, 1'b0, 12'h539, 12'h000, 0);
    run_txn(1'b0, 1'b1, 12'h539, 12'h111, 2);
    run_txn(1'b0, 1'b0, 12'h539, 12'h000, 0);

    // Reset while the store pulse is live: the write must never reach memory.
    @(negedge clk);
    sel       = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 12'h077;
    req_wdata = 12'h0F0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_eq("pre_rst_mem_we", o_mem_we, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_kill_we", o_mem_we, 0);
    check_eq("rst_kill_ready", o_req_ready, 0);
    check_eq("rst_kill_valid", o_rsp_valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_ready", o_req_ready, 1);
    repeat (3) begin
      check_eq("post_rst_no_rsp", o_rsp_valid, 0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b0;
    run_txn(1'b0, 1'b0, 12'h077, 12'h000, 0);

    for (int a = 0; a <= 12'hFFE; a++) begin
      run_txn(1'b0, 1'b1, 12'(a), 12'(a), 0);
      run_txn(1'b0, 1'b0, 12'(a), 12'h000, 0);
    end

    repeat (300) begin
      run_txn(1'($urandom), 1'($urandom), 12'($urandom), 12'($urandom),
              $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
